// File: rtl/b10_comma_align.sv
// rtl/b10_comma_align.sv - K28.5 word aligner ahead of the 8b/10b decoder
module b10_comma_align #(
  parameter int LOCK_COMMAS     = 3,
  parameter int UNLOCK_MISALIGN = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_n,
  input  logic [9:0] raw_data,
  output logic [9:0] aligned_data,
  output logic       aligned_valid,
  output logic       locked,
  output logic [3:0] align_offset,
  output logic       comma_det
);

  localparam logic [9:0] K28_5_NEG  = 10'h17C;
  localparam logic [9:0] K28_5_POS  = 10'h283;
  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COMMAS);
  localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_MISALIGN);

  typedef enum logic [1:0] {UNLOCKED, CHECK, LOCKED} state_t;

  state_t      state_q, state_n;
  logic [9:0]  prev_q;
  logic [3:0]  off_q, off_n;
  logic [3:0]  good_cnt, good_n, good_inc;
  logic [3:0]  bad_cnt, bad_n, bad_inc;
  logic [19:0] win;
  logic [9:0]  cand [10];
  logic        hit;
  logic [3:0]  hit_k;
  logic [3:0]  sel;
  logic [9:0]  sel_data;

  assign win = {raw_data, prev_q};

  // Scan from the top down so the lowest matching offset is the one kept.
  always_comb begin
    hit   = 1'b0;
    hit_k = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      cand[k] = win[k +: 10];
      if (cand[k] == K28_5_NEG || cand[k] == K28_5_POS) begin
        hit   = 1'b1;
        hit_k = 4'(k);
      end
    end
  end

  always_comb begin
    sel      = (state_q != LOCKED && hit) ? hit_k : off_q;
    sel_data = 10'h000;
    for (int k = 0; k < 10; k++) begin
      if (sel == 4'(k)) sel_data = cand[k];
    end
  end

  assign good_inc = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
  assign bad_inc  = (bad_cnt == 4'hF) ? bad_cnt : bad_cnt + 4'd1;

  always_comb begin
    state_n = state_q;
    off_n   = off_q;
    good_n  = good_cnt;
    bad_n   = bad_cnt;
    if (hit) begin
      unique case (state_q)
        UNLOCKED: begin
          off_n   = hit_k;
          good_n  = 4'd1;
          state_n = (LOCK_CNT == 4'd1) ? LOCKED : CHECK;
        end
        CHECK: begin
          if (hit_k == off_q) begin
            good_n = good_inc;
            if (good_inc >= LOCK_CNT) state_n = LOCKED;
          end else begin
            off_n  = hit_k;
            good_n = 4'd1;
          end
        end
        LOCKED: begin
          if (hit_k == off_q) begin
            bad_n = 4'd0;
          end else if (bad_inc >= UNLOCK_CNT) begin
            // Offset is kept; the next comma found while unlocked re-seeds it.
            state_n = UNLOCKED;
            good_n  = 4'd0;
            bad_n   = 4'd0;
          end else begin
            bad_n = bad_inc;
          end
        end
        default: state_n = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= UNLOCKED;
      prev_q        <= 10'h000;
      off_q         <= 4'd0;
      good_cnt      <= 4'd0;
      bad_cnt       <= 4'd0;
      aligned_data  <= 10'h000;
      aligned_valid <= 1'b0;
      locked        <= 1'b0;
      align_offset  <= 4'd0;
      comma_det     <= 1'b0;
    end else if (en_n) begin
      aligned_valid <= 1'b0;
      comma_det     <= 1'b0;
    end else begin
      state_q       <= state_n;
      prev_q        <= raw_data;
      off_q         <= off_n;
      good_cnt      <= good_n;
      bad_cnt       <= bad_n;
      aligned_data  <= sel_data;
      comma_det     <= hit && (hit_k == sel);
      locked        <= (state_n == LOCKED);
      aligned_valid <= (state_n == LOCKED);
      align_offset  <= off_n;
    end
  end

endmodule

// File: doc/b10_comma_align.md
# b10_comma_align

Word-alignment stage directly upstream of the 8b/10b decoder. It takes an unaligned 10-bit parallel stream from the deserializer and searches a 20-bit sliding window for the K28.5 comma. It locks to a bit offset after repeated consistent commas and emits aligned 10-bit code groups, which feed the decoder's `rxdata` input. It also reports lock status and the bit offset it is using.

## Interface
Parameters:
- `LOCK_COMMAS`, default 3: number of consecutive same-offset commas needed to declare lock. Legal range 1..15.
- `UNLOCK_MISALIGN`, default 2: number of consecutive wrong-offset commas, while locked, that force loss of lock. Legal range 1..15.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  synchronous reset, active-low.
- `en_n`  in  1  active-low enable. When high, all state is held.
- `raw_data`  in  10  unaligned word from the deserializer. Bit 0 is the earliest received bit.
- `aligned_data`  out  10  aligned code group, in the same bit order, to the decoder.
- `aligned_valid`  out  1  `aligned_data` is valid and the block is locked.
- `locked`  out  1  alignment FSM is in LOCKED.
- `align_offset`  out  4  current bit offset, 0..9.
- `comma_det`  out  1  `aligned_data` in this cycle is a K28.5.

## Operation
- `prev_q` is a 10-bit register holding the previous `raw_data`. Window `w[19:0] = {raw_data, prev_q}`.
- Candidate `c[k] = w[k+9:k]` for k = 0..9.
- Comma match is either K28.5 disparity: 10'h17C (RD−, abcdeifghj = 0011111010) or 10'h283 (RD+).
- If several k match in one cycle, the lowest k wins. `hit` means any k matched; `hit_k` is the winning k.
- Offset register `off_q` has reset value 0. Selected offset: `sel = hit_k` when state ≠ LOCKED and `hit`; otherwise `sel = off_q`.
- Counters: `good_cnt` and `bad_cnt`, each 4 bits, saturating.
- FSM states: UNLOCKED, CHECK, LOCKED.
  - UNLOCKED, `hit`: `off_q <= hit_k`, `good_cnt <= 1`. Go to CHECK, or directly to LOCKED if `LOCK_COMMAS == 1`.
  - CHECK, `hit` with `hit_k == off_q`: `good_cnt++`. Go to LOCKED when the count reaches `LOCK_COMMAS`.
  - CHECK, `hit` with `hit_k != off_q`: `off_q <= hit_k`, `good_cnt <= 1`, stay in CHECK.
  - LOCKED, `hit` with `hit_k == off_q`: `bad_cnt <= 0`.
  - LOCKED, `hit` with `hit_k != off_q`: `bad_cnt++`. When it reaches `UNLOCK_MISALIGN`, go to UNLOCKED and clear `good_cnt` and `bad_cnt`. `off_q` is unchanged.
  - No `hit`: no state or counter change.
- Output registers update every enabled cycle:
  - `aligned_data <= c[sel]`
  - `comma_det <= hit && hit_k == sel`
  - `locked <=` next state is LOCKED
  - `aligned_valid <=` next state is LOCKED
  - `align_offset <=` next `off_q`
- `en_n = 1`:
  - `prev_q`, FSM, counters, `off_q`, `aligned_data`, `align_offset` and `locked` hold their values.
  - `aligned_valid <= 0` and `comma_det <= 0`.
- Non-comma data is never checked for validity; code errors are the decoder's job.

## Timing
- All outputs reset to 0 on the cycle after `reset_n` is sampled low: `aligned_data` = 10'h000; `aligned_valid`, `locked`, `comma_det` = 0; `align_offset` = 0. Reset state is UNLOCKED, with `prev_q` = 0 and both counters 0.
- Reset overrides `en_n`. Reset in any state, including mid-CHECK, returns to UNLOCKED and the count restarts from zero.
- Latency:
  - Window to output is 1 cycle.
  - A comma straddling two words, with its last bit in `raw_data` at cycle t, appears whole on `aligned_data` at t+1 with `comma_det = 1`.
- `locked` and `aligned_valid` rise in the cycle after the `LOCK_COMMAS`-th good comma is in the window, coincident with that comma on `aligned_data`.
- They fall in the cycle after the `UNLOCK_MISALIGN`-th bad comma.
- The first comma that establishes an offset is already output aligned at that offset.

## Test plan
- **Reset:** hold `reset_n` = 0 for 3 cycles with random `raw_data` → all outputs 0 and `align_offset` = 0. After release, with no commas sent, `locked` stays 0.
- **Lock at offset 3:** stream commas 10'h17C/10'h283 shifted by 3 bits, one comma every 4 words, defaults → `locked` = 1 one cycle after the 3rd comma, `align_offset` = 3, `aligned_data` = 17C/283 with `comma_det` = 1 on comma cycles.
- **Interrupted CHECK:** comma at offset 3, then at offset 5, then two more at offset 5 → `locked` rises after the 3rd comma at offset 5 and `align_offset` = 5.
- **Slip while locked:** lock at offset 3, then two commas at offset 6 → `locked` = 0 after the 2nd. Three further commas at offset 6 → relock with `align_offset` = 6.
- **Bad count clearing:** locked at offset 3, then commas at offsets 6, 3, 6 → `locked` stays 1.
- **Enable gating:** locked, then `en_n` = 1 for 5 cycles → `aligned_valid` = 0, `locked` stays 1, `aligned_data` held. When `en_n` returns to 0, `aligned_valid` = 1 on the next cycle.
